// File: rtl/tog_pulse_rx_if.sv
// rtl/tog_pulse_rx_if.sv - valid/ready event handshake between the toggle receiver and its consumer
interface tog_pulse_rx_if;
   logic evt_valid;
   logic evt_ready;

   // Event source: presents pending events and observes the consumer's acceptance.
   modport master (
      output evt_valid,
      input  evt_ready
   );

   // Event consumer: sees pending events and accepts them.
   modport slave (
      input  evt_valid,
      output evt_ready
   );
endinterface

// File: rtl/tog_pulse_rx.sv
// rtl/tog_pulse_rx.sv - toggle-event link receiver with saturating pending queue and toggle ack
module tog_pulse_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4,
   parameter int TOT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tog_in,
   input  logic             clr_ovf,
   tog_pulse_rx_if.master   evt,
   output logic [CNT_W-1:0] pend_cnt,
   output logic [TOT_W-1:0] evt_total,
   output logic             ovf,
   output logic             ack_tog
);

   localparam logic [CNT_W-1:0] CNT_FULL = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [TOT_W-1:0] TOT_ONE  = TOT_W'(1);

   // The synchroniser and edge tracker power up at 0 and are deliberately left out of reset,
   // so a level present while rst is held is absorbed without producing an event.
   logic [SYNC_STAGES-1:0] sync     = '0;
   logic                   tog_prev = 1'b0;

   logic tog_edge;
   logic pop;

   assign tog_edge      = sync[SYNC_STAGES-1] ^ tog_prev;
   assign evt.evt_valid = (pend_cnt != '0);
   assign pop           = evt.evt_valid & evt.evt_ready;

   // Bring the asynchronous toggle level into clk and remember the last synchronised level.
   always_ff @(posedge clk) begin
      sync     <= {sync[SYNC_STAGES-2:0], tog_in};
      tog_prev <= sync[SYNC_STAGES-1];
   end

   // Queue detected events, count all of them, flag drops when full and toggle ack per accepted event.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_cnt  <= '0;
         evt_total <= '0;
         ovf       <= 1'b0;
         ack_tog   <= 1'b0;
      end else begin
         if (tog_edge)
            evt_total <= evt_total + TOT_ONE;

         if (pop)
            ack_tog <= ~ack_tog;

         // A drop only happens when an edge arrives with no simultaneous pop and the queue is full;
         // a drop in the same cycle as clr_ovf keeps ovf set.
         if (tog_edge && !pop && (pend_cnt == CNT_FULL))
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;

         case ({tog_edge, pop})
            2'b10: if (pend_cnt != CNT_FULL) pend_cnt <= pend_cnt + CNT_ONE;
            2'b01: pend_cnt <= pend_cnt - CNT_ONE;
            default: pend_cnt <= pend_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_tog_pulse_rx.sv
// tb/tb_tog_pulse_rx.sv - directed self-checking bench for tog_pulse_rx
module tb_tog_pulse_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        tog_in;
   logic        clr_ovf;
   logic [3:0]  pend_cnt;
   logic [15:0] evt_total;
   logic        ovf;
   logic        ack_tog;

   int checks = 0;
   int errors = 0;

   tog_pulse_rx_if evt_bus ();

   tog_pulse_rx #(
      .SYNC_STAGES (2),
      .CNT_W       (4),
      .TOT_W       (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tog_in    (tog_in),
      .clr_ovf   (clr_ovf),
      .evt       (evt_bus.master),
      .pend_cnt  (pend_cnt),
      .evt_total (evt_total),
      .ovf       (ovf),
      .ack_tog   (ack_tog)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst               = 1'b1;
      tog_in            = 1'b0;
      clr_ovf           = 1'b0;
      evt_bus.evt_ready = 1'b0;

      // 1: reset state, then ready with nothing pending is ignored
      step(5);
      chk("rst_pend", 32'(pend_cnt), 0);
      chk("rst_valid", 32'(evt_bus.evt_valid), 0);
      chk("rst_ack", 32'(ack_tog), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_total", 32'(evt_total), 0);
      rst = 1'b0;
      evt_bus.evt_ready = 1'b1;
      step(3);
      chk("idle_ready_pend", 32'(pend_cnt), 0);
      chk("idle_ready_ack", 32'(ack_tog), 0);

      // 2: latency of a single event with ready held high
      tog_in = 1'b1;
      step(1);
      chk("lat_n0_valid", 32'(evt_bus.evt_valid), 0);
      step(1);
      chk("lat_n1_valid", 32'(evt_bus.evt_valid), 0);
      step(1);
      chk("lat_n2_valid", 32'(evt_bus.evt_valid), 1);
      chk("lat_n2_ack", 32'(ack_tog), 0);
      step(1);
      chk("lat_n3_valid", 32'(evt_bus.evt_valid), 0);
      chk("lat_n3_ack", 32'(ack_tog), 1);
      chk("lat_total", 32'(evt_total), 1);

      // 3: queue five events, then drain back to back
      evt_bus.evt_ready = 1'b0;
      rst = 1'b1;
      step(4);
      rst = 1'b0;
      chk("q_rst_ack", 32'(ack_tog), 0);
      chk("q_rst_total", 32'(evt_total), 0);
      for (int i = 0; i < 5; i++) begin
         tog_in = ~tog_in;
         step(4);
      end
      chk("q_pend", 32'(pend_cnt), 5);
      chk("q_total", 32'(evt_total), 5);
      chk("q_ack_hold", 32'(ack_tog), 0);
      evt_bus.evt_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("drain_valid", 32'(evt_bus.evt_valid), 1);
         chk("drain_pend", 32'(pend_cnt), 32'(5 - i));
         step(1);
      end
      evt_bus.evt_ready = 1'b0;
      chk("drain_end_pend", 32'(pend_cnt), 0);
      chk("drain_end_valid", 32'(evt_bus.evt_valid), 0);
      chk("drain_end_ack", 32'(ack_tog), 1);

      // 4: saturation, overflow, clear, and drop coincident with clear
      rst = 1'b1;
      step(4);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tog_in = ~tog_in;
         step(4);
      end
      chk("sat_pend", 32'(pend_cnt), 15);
      chk("sat_ovf", 32'(ovf), 1);
      chk("sat_total", 32'(evt_total), 16);
      chk("sat_ack", 32'(ack_tog), 0);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("clr_ovf", 32'(ovf), 0);
      tog_in = ~tog_in;
      step(2);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("drop_vs_clr_ovf", 32'(ovf), 1);
      chk("drop_vs_clr_pend", 32'(pend_cnt), 15);
      chk("drop_vs_clr_total", 32'(evt_total), 17);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      chk("clr_ovf_again", 32'(ovf), 0);

      // 5: edge coincident with pop at full, then at pend_cnt=3
      tog_in = ~tog_in;
      step(2);
      evt_bus.evt_ready = 1'b1;
      step(1);
      evt_bus.evt_ready = 1'b0;
      chk("coinc15_pend", 32'(pend_cnt), 15);
      chk("coinc15_ovf", 32'(ovf), 0);
      chk("coinc15_ack", 32'(ack_tog), 1);
      chk("coinc15_total", 32'(evt_total), 18);
      evt_bus.evt_ready = 1'b1;
      step(12);
      evt_bus.evt_ready = 1'b0;
      chk("to3_pend", 32'(pend_cnt), 3);
      chk("to3_ack", 32'(ack_tog), 1);
      tog_in = ~tog_in;
      step(2);
      evt_bus.evt_ready = 1'b1;
      step(1);
      evt_bus.evt_ready = 1'b0;
      chk("coinc3_pend", 32'(pend_cnt), 3);
      chk("coinc3_ack", 32'(ack_tog), 0);
      chk("coinc3_total", 32'(evt_total), 19);
      chk("coinc3_ovf", 32'(ovf), 0);

      // 6: level change absorbed during reset, then reset mid-operation
      tog_in = 1'b0;
      step(4);
      tog_in = 1'b1;
      rst = 1'b1;
      step(4);
      rst = 1'b0;
      step(6);
      chk("absorb_pend", 32'(pend_cnt), 0);
      chk("absorb_valid", 32'(evt_bus.evt_valid), 0);
      chk("absorb_total", 32'(evt_total), 0);
      for (int i = 0; i < 7; i++) begin
         tog_in = ~tog_in;
         step(4);
      end
      chk("pre_rst_pend", 32'(pend_cnt), 7);
      rst = 1'b1;
      step(1);
      chk("mid_rst_pend", 32'(pend_cnt), 0);
      chk("mid_rst_valid", 32'(evt_bus.evt_valid), 0);
      chk("mid_rst_total", 32'(evt_total), 0);
      step(3);
      rst = 1'b0;
      step(4);
      chk("post_rst_pend", 32'(pend_cnt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
